lcd_hd44780_rx: RTL

- Responder end of the text-LCD bus: a synthesizable HD44780-style controller that accepts the lcd_e/lcd_rs/lcd_rw/lcd_data writes our LCD driver issues.
- Decodes commands and maintains a 2x16 display RAM plus display/entry state.
- Exposes a scan read port so the text can be mirrored to another output or checked on-chip.
- Runs on the fast system clock; lcd_e is a slow asynchronous strobe.

---
 rtl/lcd_hd44780_rx_pkg.sv | 47 ++++
 rtl/lcd_hd44780_rx_if.sv | 17 +
 rtl/lcd_hd44780_rx_bus_sync.sv | 68 ++++++
 rtl/lcd_hd44780_rx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lcd_hd44780_rx_pkg.sv
// Shared constants, state type and address-stepping helper for the
// HD44780-style LCD responder.
package lcd_pkg;

  localparam int ADDR_W = 5;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [7:0] FILL_CHAR_DEF = 8'h20;

  typedef enum logic {ST_CLEAR, ST_IDLE} lcd_state_t;

  // Move {line, col} one position; wrapping past either end of a line goes
  // to the other line in two-line mode, otherwise stays on line 0.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic inc,
                                                  input logic two);
    logic       line;
    logic [3:0] col;
    line = a[4];
    col  = a[3:0];
    if (inc) begin
      if (col == 4'hF) begin
        col  = 4'h0;
        line = two & ~line;
      end else begin
        col = col + 4'd1;
      end
    end else begin
      if (col == 4'h0) begin
        col  = 4'hF;
        line = two & ~line;
      end else begin
        col = col - 4'd1;
      end
    end
    return {line, col};
  endfunction

endpackage

// File: rtl/lcd_hd44780_rx_if.sv
// LCD bus seen from the controller side. Optional busy/address readback
// lines exist only when LCD_READ_BUSY_EN is defined.
interface lcd_hd44780_rx_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
`ifdef LCD_READ_BUSY_EN
  logic [7:0] lcd_dout;
  logic       lcd_doe;
  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data, input lcd_dout, lcd_doe);
  modport slave  (input lcd_e, lcd_rs, lcd_rw, lcd_data, output lcd_dout, lcd_doe);
`else
  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data);
  modport slave  (input lcd_e, lcd_rs, lcd_rw, lcd_data);
`endif
endinterface

// File: rtl/lcd_hd44780_rx_bus_sync.sv
// Synchronizer chain for the slow LCD bus plus falling-edge detector on E.
// o_fall is a one-cycle strobe; rs/rw/data come from the same stage as the
// E sample that produced it. o_e exists only with LCD_READ_BUSY_EN.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_e,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [7:0] i_data,
`ifdef LCD_READ_BUSY_EN
  output logic       o_e,
`endif
  output logic       o_fall,
  output logic       o_rs,
  output logic       o_rw,
  output logic [7:0] o_data
);

  localparam int W = 11;

  logic [SYNC_STAGES-1:0][W-1:0] r_sync;
  logic [SYNC_STAGES-1:0][W-1:0] w_d;
  logic [W-1:0]                  w_last;
  logic                          r_e_prev;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_d[gi] = {i_e, i_rs, i_rw, i_data};
      end else begin : g_tail
        assign w_d[gi] = r_sync[gi-1];
      end
    end
  endgenerate

  // Shift every bus bit through the synchronizer stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= w_d;
    end
  end

  assign w_last = r_sync[SYNC_STAGES-1];

  // Remember the previous synchronized E for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e_prev <= 1'b0;
    end else begin
      r_e_prev <= w_last[10];
    end
  end

  assign o_fall = r_e_prev & ~w_last[10];
  assign o_rs   = w_last[9];
  assign o_rw   = w_last[8];
  assign o_data = w_last[7:0];
`ifdef LCD_READ_BUSY_EN
  assign o_e    = w_last[10];
`endif

endmodule

// File: rtl/lcd_hd44780_rx.sv
// HD44780-style LCD responder: decodes bus writes into a 2x16 display RAM
// and display/entry state, with a registered scan read port.
// Optional busy/address readback on the bus: define LCD_READ_BUSY_EN.
module lcd_hd44780_rx
  import lcd_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] FILL_CHAR    = FILL_CHAR_DEF,
  parameter int         CLEAR_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  lcd_hd44780_rx_if.slave   bus,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              disp_on,
  output logic              cursor_on,
  output logic              blink_on,
  output logic              two_line,
  output logic              inc_mode,
  output logic              busy,
  output logic              cmd_strobe,
  output logic              overrun
);

  localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);

  logic              w_fall, w_rs, w_rw, w_wr, w_accept, w_we;
  logic [7:0]        w_data, w_wdata;
  logic [ADDR_W-1:0] w_waddr;
`ifdef LCD_READ_BUSY_EN
  logic              w_e;
`endif

  lcd_state_t        r_state;
  logic              r_busy, r_strobe, r_overrun;
  logic [7:0]        r_clr_cnt;
  logic [ADDR_W-1:0] r_cur;
  logic              r_disp, r_cursor, r_blink, r_two, r_inc;
  logic [7:0]        r_ram [2**ADDR_W];
  logic [7:0]        r_rd_data;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_e    (bus.lcd_e),
    .i_rs   (bus.lcd_rs),
    .i_rw   (bus.lcd_rw),
    .i_data (bus.lcd_data),
`ifdef LCD_READ_BUSY_EN
    .o_e    (w_e),
`endif
    .o_fall (w_fall),
    .o_rs   (w_rs),
    .o_rw   (w_rw),
    .o_data (w_data)
  );

  assign w_wr     = w_fall & ~w_rw;
  assign w_accept = w_wr & ~r_busy;

  // Control FSM: sequential clear sweep, then command/data decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_CLEAR;
      r_busy    <= 1'b1;
      r_clr_cnt <= '0;
      r_cur     <= '0;
      r_disp    <= 1'b0;
      r_cursor  <= 1'b0;
      r_blink   <= 1'b0;
      r_two     <= 1'b0;
      r_inc     <= 1'b1;
      r_strobe  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_strobe <= w_accept;
      if (w_wr && r_busy) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == CLR_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 8'd1;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            if (w_rs) begin
              r_cur <= step_addr(r_cur, r_inc, r_two);
            end else if ((w_data & CMD_DDRAM) != 8'h00) begin
              r_cur <= {w_data[6] & r_two, w_data[3:0]};
            end else if ((w_data & CMD_CGRAM) != 8'h00) begin
              // Character generator RAM is not modelled.
              r_cur <= r_cur;
            end else if ((w_data & CMD_FUNC) != 8'h00) begin
              r_two <= w_data[3];
              if (!w_data[3]) begin
                r_cur[4] <= 1'b0;
              end
            end else if ((w_data & CMD_SHIFT) != 8'h00) begin
              if (!w_data[3]) begin
                r_cur <= step_addr(r_cur, w_data[2], r_two);
              end
            end else if ((w_data & CMD_DISP) != 8'h00) begin
              r_disp   <= w_data[2];
              r_cursor <= w_data[1];
              r_blink  <= w_data[0];
            end else if ((w_data & CMD_ENTRY) != 8'h00) begin
              r_inc <= w_data[1];
            end else if ((w_data & CMD_HOME) != 8'h00) begin
              r_cur <= '0;
            end else if (w_data == CMD_CLEAR) begin
              r_state   <= ST_CLEAR;
              r_busy    <= 1'b1;
              r_clr_cnt <= '0;
              r_cur     <= '0;
              r_inc     <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The clear sweep owns the single RAM write port while busy.
  assign w_we    = r_busy | (w_accept & w_rs);
  assign w_waddr = r_busy ? r_clr_cnt[ADDR_W-1:0] : r_cur;
  assign w_wdata = r_busy ? FILL_CHAR : w_data;

  // Display RAM write port.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_ram[w_waddr] <= w_wdata;
    end
  end

  // Registered scan read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_ram[rd_addr];
    end
  end

`ifdef LCD_READ_BUSY_EN
  // Busy flag and address readback while the host holds a status read.
  always_comb begin
    bus.lcd_doe  = 1'b0;
    bus.lcd_dout = 8'h00;
    if (w_e && !w_rs && w_rw) begin
      bus.lcd_doe  = 1'b1;
      bus.lcd_dout = {r_busy, 2'b00, r_cur};
    end
  end
`endif

  assign rd_data    = r_rd_data;
  assign cur_addr   = r_cur;
  assign disp_on    = r_disp;
  assign cursor_on  = r_cursor;
  assign blink_on   = r_blink;
  assign two_line   = r_two;
  assign inc_mode   = r_inc;
  assign busy       = r_busy;
  assign cmd_strobe = r_strobe;
  assign overrun    = r_overrun;

endmodule
